// File: rtl/ifq_pkg.sv
// Shared types and helpers for the instruction fetch queue.
// The optional Thumb-2 support is selected by the IFQ_THUMB2_EN macro in inst_fetch_queue.
package ifq_pkg;

  typedef enum logic [1:0] {
    FETCH   = 2'd0,
    HOLD    = 2'd1,
    DISCARD = 2'd2
  } ifq_state_t;

  // Leading five bits that mark the first halfword of a 32-bit Thumb-2 instruction.
  localparam logic [4:0] T32_PFX_A = 5'b11101;
  localparam logic [4:0] T32_PFX_B = 5'b11110;
  localparam logic [4:0] T32_PFX_C = 5'b11111;

  function automatic logic is_thumb32(input logic [15:0] hw);
    return (hw[15:11] == T32_PFX_A) || (hw[15:11] == T32_PFX_B) ||
           (hw[15:11] == T32_PFX_C);
  endfunction

endpackage

// File: rtl/ifq_hw_buffer.sv
// Circular halfword buffer: up to two halfwords written and two read per cycle.
// The clr input empties the queue by snapping rd_ptr onto wr_ptr.
module ifq_hw_buffer #(
  parameter int DEPTH     = 4,
  parameter bit LOOKAHEAD = 1'b1,
  localparam int AW       = $clog2(DEPTH),
  localparam int CW       = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [1:0]    wr_n,
  input  logic [15:0]   wr_d0,
  input  logic [15:0]   wr_d1,
  input  logic [1:0]    rd_n,
  output logic [15:0]   q0,
  output logic [15:0]   q1,
  output logic [CW-1:0] count
);

  logic [15:0]   mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;

  // NOTE: storage has no reset; the outputs below are masked by count, so stale
  // contents are never visible and the array can map onto plain registers or RAM.
  always_ff @(posedge clk) begin
    if (!clr) begin
      if (wr_n != 2'd0) mem[wr_ptr] <= wr_d0;
      if (wr_n == 2'd2) mem[wr_ptr + AW'(1)] <= wr_d1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clr) begin
      rd_ptr <= wr_ptr;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(wr_n);
      rd_ptr <= rd_ptr + AW'(rd_n);
      count  <= count + CW'(wr_n) - CW'(rd_n);
    end
  end

  assign q0 = (count != '0) ? mem[rd_ptr] : 16'h0000;
  assign q1 = (LOOKAHEAD && (count >= CW'(2))) ? mem[rd_ptr + AW'(1)] : 16'h0000;

endmodule

// File: rtl/inst_fetch_queue.sv
// Thumb prefetch queue: word fetch FSM, PC tracking and branch redirect.
// Define IFQ_THUMB2_EN to enable 32-bit instruction detection and two-halfword consume.
module inst_fetch_queue
  import ifq_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic [31:0] flush_addr,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        dec_valid,
  input  logic        dec_ready,
  output logic [15:0] ir_q0,
  output logic [15:0] ir_q1,
  output logic        dec_is32,
  output logic [31:0] dec_pc
);

`ifdef IFQ_THUMB2_EN
  localparam bit THUMB2 = 1'b1;
`else
  localparam bit THUMB2 = 1'b0;
`endif

  localparam int CW = $clog2(DEPTH) + 1;

  ifq_state_t    state, state_nxt;
  logic [31:0]   fa;
  logic [31:0]   disc_addr;
  logic          drop_low;
  logic [CW-1:0] count;
  logic [CW-1:0] count_after;
  logic          req_pending;
  logic          ack_take;
  logic          accept;
  logic [1:0]    wr_n;
  logic [1:0]    rd_n;

  // Held in reset, the request is masked so no read escapes before release.
  assign req_pending = (state != HOLD);
  assign mem_req     = rst_n & req_pending;
  assign mem_addr    = !mem_req ? 32'h0 : (state == DISCARD) ? disc_addr : fa;

  assign ack_take  = (state == FETCH) && mem_ack && !flush;
  assign wr_n      = !ack_take ? 2'd0 : drop_low ? 2'd1 : 2'd2;

  assign dec_is32  = THUMB2 && is_thumb32(ir_q0);
  assign dec_valid = ((count >= CW'(1)) && !dec_is32) || (count >= CW'(2));
  assign accept    = dec_valid && dec_ready && !flush;
  assign rd_n      = !accept ? 2'd0 : dec_is32 ? 2'd2 : 2'd1;

  assign count_after = count + CW'(wr_n) - CW'(rd_n);

  ifq_hw_buffer #(
    .DEPTH    (DEPTH),
    .LOOKAHEAD(THUMB2)
  ) u_buf (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (flush),
    .wr_n (wr_n),
    .wr_d0(drop_low ? mem_rdata[31:16] : mem_rdata[15:0]),
    .wr_d1(mem_rdata[31:16]),
    .rd_n (rd_n),
    .q0   (ir_q0),
    .q1   (ir_q1),
    .count(count)
  );

  // NOTE: next-state is defaulted first so no path through the block leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH:   if (mem_ack && (count_after > CW'(DEPTH - 2))) state_nxt = HOLD;
      HOLD:    if (count_after <= CW'(DEPTH - 2)) state_nxt = FETCH;
      DISCARD: if (mem_ack) state_nxt = FETCH;
      default: state_nxt = FETCH;
    endcase
    if (flush) state_nxt = (req_pending && !mem_ack) ? DISCARD : FETCH;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fa        <= RESET_PC & ~32'h3;
      drop_low  <= RESET_PC[1];
      dec_pc    <= RESET_PC;
      disc_addr <= 32'h0;
    end else if (flush) begin
      fa       <= flush_addr & ~32'h3;
      drop_low <= flush_addr[1];
      dec_pc   <= flush_addr & ~32'h1;
      // A still-open read keeps its original address until its ack is dropped.
      if (state == FETCH) disc_addr <= fa;
    end else begin
      if (ack_take) begin
        fa       <= fa + 32'd4;
        drop_low <= 1'b0;
      end
      if (accept) dec_pc <= dec_pc + (dec_is32 ? 32'd4 : 32'd2);
    end
  end

endmodule
